hazard_unit: RTL
================

Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage RV64 core.
- Consumes register addresses, write enables, branch-taken and load flags from the datapath, plus I/D-cache miss levels.
- Produces the fetch/decode stalls, decode/execute flushes and rs1/rs2 forward selects that the datapath consumes.
- Adds an I-cache/D-cache miss FSM, a full-pipe freeze output, an I-cache abort handshake and saturating stall/flush performance counters.

Parameters:
- REG_ADDR_W, 5: register address width.
- CNT_WIDTH, 32: performance counter width.

Ports:
- i_clk  in  1  clock
- i_arst  in  1  asynchronous reset, active-low
- i_rs1_addr_dec, i_rs2_addr_dec  in  REG_ADDR_W  decode-stage sources
- i_rs1_addr_exec, i_rs2_addr_exec  in  REG_ADDR_W  execute-stage sources
- i_rd_addr_exec, i_rd_addr_mem, i_rd_addr_wb  in  REG_ADDR_W  destinations per stage
- i_reg_we_mem, i_reg_we_wb  in  1  register write enable per stage
- i_pc_src_exec  in  1  branch/jump taken in execute
- i_load_instr_exec  in  1  load in execute
- i_icache_miss  in  1  level; high until refill completes
- i_dcache_miss  in  1  level; high until refill completes
- o_stall_fetch, o_stall_dec  out  1  hold PC / fetch-decode register
- o_flush_dec, o_flush_exec  out  1  bubble into decode / execute register
- o_stall_pipe  out  1  freeze execute, memory and write-back registers
- o_forward_rs1, o_forward_rs2  out  2  forward selects
- o_icache_abort  out  1  one-cycle pulse: drop the outstanding wrong-path refill
- o_stall_cycles  out  CNT_WIDTH  cycles with o_stall_dec=1
- o_flush_count  out  CNT_WIDTH  branch redirects taken

Behaviour:
- Reset (i_arst=0): state=RUN, counters=0. All control outputs forced to 0 while reset is asserted, including mid-miss.
- Forwarding is combinational and evaluated in every state:
  - FWD_MEM=2'b10 if i_reg_we_mem, i_rd_addr_mem==rs_exec and rs_exec!=0.
  - Else FWD_WB=2'b01 if i_reg_we_wb, i_rd_addr_wb==rs_exec and rs_exec!=0.
  - Else FWD_RF=2'b00.
  - MEM beats WB.
- lw_hazard = i_load_instr_exec & rd_exec!=0 & (rd_exec==rs1_dec | rd_exec==rs2_dec).
- FSM states are RUN, ISTALL, DSTALL. Outputs are Mealy from state and inputs; priority is highest first:
  - RUN:
    - i_dcache_miss: stall_fetch=stall_dec=stall_pipe=1; next DSTALL.
    - else i_pc_src_exec: flush_dec=flush_exec=1, no stalls. A simultaneous icache_miss is ignored and o_icache_abort=1 if it is high. Next RUN.
    - else i_icache_miss: stall_fetch=stall_dec=1, flush_exec=1; next ISTALL.
    - else lw_hazard: stall_fetch=stall_dec=1, flush_exec=1 (one bubble, 1-cycle penalty).
    - else all 0.
  - ISTALL:
    - i_dcache_miss: full freeze; next DSTALL.
    - else i_pc_src_exec (older branch resolving): flush_dec=flush_exec=1, stall_fetch=0, o_icache_abort=1; next RUN.
    - else i_icache_miss: stall_fetch=stall_dec=1, flush_exec=1 so older instructions drain; stay.
    - else: outputs as in RUN with icache_miss=0; next RUN.
  - DSTALL:
    - i_dcache_miss: stall_fetch=stall_dec=stall_pipe=1, no flushes, i_pc_src_exec ignored (execute is frozen, so it persists); stay.
    - else: outputs as in RUN; next RUN, or ISTALL if i_icache_miss.
- A flush never coincides with stall_pipe=1.
- Counters: o_stall_cycles +1 each cycle o_stall_dec=1. o_flush_count +1 each cycle flush_dec=1 due to pc_src. Both saturate at all-ones; no wrap.

Decomposition:
- hazard_pkg holds the state enum (RUN, ISTALL, DSTALL) and the FWD_RF/FWD_WB/FWD_MEM constants.
- Sub-module forward_select: one instance per operand, pure combinational priority compare.

Test Plan:
- MEM forward priority: rs1_exec=5, rd_mem=5, we_mem=1, rd_wb=5, we_wb=1 -> forward_rs1=2'b10. Same with rs1_exec=0 -> 2'b00.
- Load-use: load_exec=1, rd_exec=7, rs2_dec=7 -> one cycle of stall_fetch=stall_dec=flush_exec=1; o_stall_cycles=1. With rd_exec=0 -> no stall.
- Branch with I-miss: pc_src_exec=1 and icache_miss=1 in RUN -> flush_dec=flush_exec=1, icache_abort=1, state stays RUN, o_flush_count=1.
- D-miss for 4 cycles with pc_src_exec=1 held -> stall_pipe=1 for 4 cycles, no flushes; on the 5th cycle (miss=0) flush_dec=flush_exec=1; o_stall_cycles=4.
- I-miss then older branch: ISTALL for 2 cycles, then pc_src_exec=1 -> abort pulse, stall_fetch=0, next RUN.
- Reset mid-DSTALL: drop i_arst -> all outputs 0 immediately and counters 0; after release with miss=0 -> RUN, no stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forward selects
// and the bundle of stall/flush controls driven each cycle.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ISTALL = 2'd1,
        DSTALL = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic stall_fetch;
        logic stall_dec;
        logic flush_dec;
        logic flush_exec;
        logic stall_pipe;
        logic icache_abort;
    } ctrl_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Datapath <-> hazard unit signal bundle; master is the datapath side,
// slave is the hazard unit.
interface hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_WIDTH  = 32
);
    logic [REG_ADDR_W-1:0] i_rs1_addr_dec;
    logic [REG_ADDR_W-1:0] i_rs2_addr_dec;
    logic [REG_ADDR_W-1:0] i_rs1_addr_exec;
    logic [REG_ADDR_W-1:0] i_rs2_addr_exec;
    logic [REG_ADDR_W-1:0] i_rd_addr_exec;
    logic [REG_ADDR_W-1:0] i_rd_addr_mem;
    logic [REG_ADDR_W-1:0] i_rd_addr_wb;
    logic                  i_reg_we_mem;
    logic                  i_reg_we_wb;
    logic                  i_pc_src_exec;
    logic                  i_load_instr_exec;
    logic                  i_icache_miss;
    logic                  i_dcache_miss;

    logic                  o_stall_fetch;
    logic                  o_stall_dec;
    logic                  o_flush_dec;
    logic                  o_flush_exec;
    logic                  o_stall_pipe;
    logic [1:0]            o_forward_rs1;
    logic [1:0]            o_forward_rs2;
    logic                  o_icache_abort;
    logic [CNT_WIDTH-1:0]  o_stall_cycles;
    logic [CNT_WIDTH-1:0]  o_flush_count;

    modport master (
        output i_rs1_addr_dec, i_rs2_addr_dec, i_rs1_addr_exec, i_rs2_addr_exec,
               i_rd_addr_exec, i_rd_addr_mem, i_rd_addr_wb, i_reg_we_mem, i_reg_we_wb,
               i_pc_src_exec, i_load_instr_exec, i_icache_miss, i_dcache_miss,
        input  o_stall_fetch, o_stall_dec, o_flush_dec, o_flush_exec, o_stall_pipe,
               o_forward_rs1, o_forward_rs2, o_icache_abort, o_stall_cycles, o_flush_count
    );

    modport slave (
        input  i_rs1_addr_dec, i_rs2_addr_dec, i_rs1_addr_exec, i_rs2_addr_exec,
               i_rd_addr_exec, i_rd_addr_mem, i_rd_addr_wb, i_reg_we_mem, i_reg_we_wb,
               i_pc_src_exec, i_load_instr_exec, i_icache_miss, i_dcache_miss,
        output o_stall_fetch, o_stall_dec, o_flush_dec, o_flush_exec, o_stall_pipe,
               o_forward_rs1, o_forward_rs2, o_icache_abort, o_stall_cycles, o_flush_count
    );

endinterface

// File: rtl/hazard_unit_forward_select.sv
// Operand bypass select for one execute-stage source register.
// Combinational, no state; the MEM-stage result wins over the WB-stage result.
module forward_select
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rd_mem,
    input  logic                  we_mem,
    input  logic [REG_ADDR_W-1:0] rd_wb,
    input  logic                  we_wb,
    output logic [1:0]            sel
);
    logic rs_nz;

    // x0 is hardwired to zero, so it is never bypassed
    assign rs_nz = |rs;

    always_comb begin
        sel = FWD_RF;
        if (we_mem && rs_nz && (rd_mem == rs)) begin
            sel = FWD_MEM;
        end else if (we_wb && rs_nz && (rd_wb == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forward controller for the 5-stage pipeline with I/D-miss FSM and perf counters.
// Latency: controls are combinational (Mealy); counters update one cycle later; no backpressure of its own.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic         i_clk,
    input  logic         i_arst,
    hazard_unit_if.slave hif
);
    state_t               state_q;
    state_t               state_nxt;
    ctrl_t                ctrl;
    logic                 lw_hazard;
    logic [1:0]           fwd_rs1;
    logic [1:0]           fwd_rs2;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_q;

    forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
        .rs     (hif.i_rs1_addr_exec),
        .rd_mem (hif.i_rd_addr_mem),
        .we_mem (hif.i_reg_we_mem),
        .rd_wb  (hif.i_rd_addr_wb),
        .we_wb  (hif.i_reg_we_wb),
        .sel    (fwd_rs1)
    );

    forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
        .rs     (hif.i_rs2_addr_exec),
        .rd_mem (hif.i_rd_addr_mem),
        .we_mem (hif.i_reg_we_mem),
        .rd_wb  (hif.i_rd_addr_wb),
        .we_wb  (hif.i_reg_we_wb),
        .sel    (fwd_rs2)
    );

    assign lw_hazard = hif.i_load_instr_exec && (hif.i_rd_addr_exec != '0) &&
                       ((hif.i_rd_addr_exec == hif.i_rs1_addr_dec) ||
                        (hif.i_rd_addr_exec == hif.i_rs2_addr_dec));

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_nxt;
        end
    end

    // A D-miss freezes everything in every state, so the branch stays in execute until it clears
    always_comb begin
        ctrl      = '0;
        state_nxt = RUN;
        if (hif.i_dcache_miss) begin
            ctrl.stall_fetch = 1'b1;
            ctrl.stall_dec   = 1'b1;
            ctrl.stall_pipe  = 1'b1;
            state_nxt        = DSTALL;
        end else if (hif.i_pc_src_exec) begin
            ctrl.flush_dec    = 1'b1;
            ctrl.flush_exec   = 1'b1;
            ctrl.icache_abort = hif.i_icache_miss;
        end else if (hif.i_icache_miss) begin
            ctrl.stall_fetch = 1'b1;
            ctrl.stall_dec   = 1'b1;
            ctrl.flush_exec  = 1'b1;
            state_nxt        = ISTALL;
        end else if (lw_hazard) begin
            ctrl.stall_fetch = 1'b1;
            ctrl.stall_dec   = 1'b1;
            ctrl.flush_exec  = 1'b1;
        end

        unique case (state_q)
            RUN, DSTALL: ;
            ISTALL: begin
                // An older branch resolving while a refill is pending makes the refill wrong-path
                if (!hif.i_dcache_miss && hif.i_pc_src_exec) begin
                    ctrl.icache_abort = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (ctrl.stall_dec && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (ctrl.flush_dec && !(&flush_cnt_q)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign hif.o_stall_fetch  = i_arst & ctrl.stall_fetch;
    assign hif.o_stall_dec    = i_arst & ctrl.stall_dec;
    assign hif.o_flush_dec    = i_arst & ctrl.flush_dec;
    assign hif.o_flush_exec   = i_arst & ctrl.flush_exec;
    assign hif.o_stall_pipe   = i_arst & ctrl.stall_pipe;
    assign hif.o_icache_abort = i_arst & ctrl.icache_abort;
    assign hif.o_forward_rs1  = i_arst ? fwd_rs1 : FWD_RF;
    assign hif.o_forward_rs2  = i_arst ? fwd_rs2 : FWD_RF;
    assign hif.o_stall_cycles = stall_cnt_q;
    assign hif.o_flush_count  = flush_cnt_q;

endmodule
